// File: rtl/cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cu                                                          |
// | Brief  : MyCPU control unit. Fetches 16-bit instructions over a      |
// |          req/ack handshake, decodes them into FU function select,    |
// |          register-file addresses and strobes, steps the PC and       |
// |          resolves conditional branches from the latched N/Z flags.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+

package cu_pkg;
  // FU function select; only the encoding the control unit itself emits
  // is named here, ALU instructions pass IR[13:10] through unchanged.
  typedef logic [3:0] fs_t;
  localparam fs_t FMOVA = 4'h0;
endpackage

module cu
  import cu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata_in,
  input  logic        mem_ack_in,
  input  logic [15:0] a_data_in,
  input  logic [15:0] b_data_in,
  input  logic [1:0]  nz_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [15:0] mem_addr_out,
  output logic [15:0] mem_wdata_out,
  output fs_t         fs_out,
  output logic [2:0]  rf_a_addr_out,
  output logic [2:0]  rf_b_addr_out,
  output logic [2:0]  rf_d_addr_out,
  output logic        rf_we_out,
  output logic [1:0]  wb_sel_out,
  output logic [15:0] imm_out,
  output logic [15:0] pc_out,
  output logic        halted_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_SPC = 2'b11;

  localparam logic [1:0] WB_FU  = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  flags_q, flags_d;
  logic        br_taken;
  logic [15:0] br_offset;

  // State and architectural registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      flags_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Next-state sequencing of the instruction cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ack_in) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (ir_q[15:14])
          CLS_MEM: state_d = S_MEM;
          CLS_SPC: state_d = ir_q[13] ? S_HALT : S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ack_in) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Branch condition from the latched flags (N=[1], Z=[0]).
  always_comb begin
    br_offset = {{8{ir_q[7]}}, ir_q[7:0]};
    case (ir_q[13:12])
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = flags_q[0];
      2'b10:   br_taken = flags_q[1];
      default: br_taken = ~flags_q[0];
    endcase
  end

  // PC / IR / flags updates: fetch completion, taken branch, ALU flags.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    if (state_q == S_FETCH && mem_ack_in) begin
      ir_d = mem_rdata_in;
      pc_d = pc_q + 16'd1;
    end
    if (state_q == S_EXEC) begin
      if (ir_q[15:14] == CLS_BR && br_taken) begin
        pc_d = pc_q + br_offset;
      end
      if (ir_q[15:14] == CLS_ALU) begin
        flags_d = nz_in;
      end
    end
  end

  // Per-state output decode; everything idles low with FMOVA selected.
  always_comb begin
    mem_req_out   = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = 16'h0000;
    mem_wdata_out = 16'h0000;
    fs_out        = FMOVA;
    rf_we_out     = 1'b0;
    wb_sel_out    = WB_FU;
    case (state_q)
      S_FETCH: begin
        mem_req_out  = 1'b1;
        mem_addr_out = pc_q;
      end
      S_EXEC: begin
        case (ir_q[15:14])
          CLS_ALU: begin
            fs_out     = ir_q[13:10];
            rf_we_out  = 1'b1;
            wb_sel_out = WB_FU;
          end
          CLS_SPC: begin
            if (!ir_q[13]) begin
              rf_we_out  = 1'b1;
              wb_sel_out = WB_IMM;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_out   = 1'b1;
        mem_we_out    = ir_q[13];
        mem_addr_out  = a_data_in;
        mem_wdata_out = b_data_in;
        // Load data goes straight from the bus into the register file.
        if (!ir_q[13] && mem_ack_in) begin
          rf_we_out  = 1'b1;
          wb_sel_out = WB_MEM;
        end
      end
      default: ;
    endcase
  end

  assign rf_d_addr_out = ir_q[9:7];
  assign rf_a_addr_out = ir_q[6:4];
  assign rf_b_addr_out = ir_q[3:1];
  assign imm_out       = {9'b0, ir_q[6:0]};
  assign pc_out        = pc_q;
  assign halted_out    = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cu.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_cu                                                       |
// | Brief  : Bench for cu. A memory responder with programmable wait     |
// |          states and a small register file surround the DUT; an       |
// |          instruction-level model predicts every bus transfer and     |
// |          register write, plus directed timing checks.                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_cu;
  import cu_pkg::*;

  localparam logic [3:0]  FADD      = 4'h2;
  localparam logic [15:0] FU_RESULT = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_rdata_in = 16'h0;
  logic        mem_ack_in = 1'b0;
  logic [15:0] a_data_in, b_data_in;
  logic [1:0]  nz_in;
  logic        mem_req_out, mem_we_out;
  logic [15:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  fs_out;
  logic [2:0]  rf_a_addr_out, rf_b_addr_out, rf_d_addr_out;
  logic        rf_we_out;
  logic [1:0]  wb_sel_out;
  logic [15:0] imm_out, pc_out;
  logic        halted_out;

  always #5 clk = ~clk;

  cu #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in),
    .a_data_in(a_data_in), .b_data_in(b_data_in), .nz_in(nz_in),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .fs_out(fs_out),
    .rf_a_addr_out(rf_a_addr_out), .rf_b_addr_out(rf_b_addr_out),
    .rf_d_addr_out(rf_d_addr_out),
    .rf_we_out(rf_we_out), .wb_sel_out(wb_sel_out),
    .imm_out(imm_out), .pc_out(pc_out), .halted_out(halted_out)
  );

  // ---------------- environment ----------------
  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];
  logic [1:0]  nz_alu;
  logic        resp_en;
  int          wait_n;
  int          wcnt;
  int          cyc;

  assign a_data_in = rf[rf_a_addr_out];
  assign b_data_in = rf[rf_b_addr_out];
  // FADD reports nz_alu; any other select reports the complement, so a
  // flags capture at the wrong moment changes the branch outcome.
  assign nz_in = (fs_out == FADD) ? nz_alu : ~nz_alu;

  // Memory responder: ack after wait_n stall cycles of a held request.
  always @(negedge clk) begin
    if (mem_ack_in) wcnt = 0;
    mem_ack_in = 1'b0;
    if (resp_en && mem_req_out) begin
      if (wcnt >= wait_n) begin
        mem_ack_in   = 1'b1;
        mem_rdata_in = mem[mem_addr_out];
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Register file writes and preload on reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      rf[1] <= 16'h0100;
      rf[2] <= 16'hBEEF;
    end else if (rf_we_out) begin
      case (wb_sel_out)
        2'b00:   rf[rf_d_addr_out] <= FU_RESULT;
        2'b01:   rf[rf_d_addr_out] <= mem_rdata_in;
        default: rf[rf_d_addr_out] <= imm_out;
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        fetch;
  } bus_ev_t;

  typedef struct {
    logic [2:0]  d, a, b;
    logic [1:0]  wsel;
    logic [3:0]  fs;
    logic [15:0] val;
    logic [15:0] pc;
  } rf_ev_t;

  bus_ev_t bq[$];
  rf_ev_t  rq[$];
  int      fetch_cyc[$];
  logic    chk_en = 1'b0;
  bus_ev_t be;
  rf_ev_t  re;

  // Instruction-level model: walk the program from RESET_PC and list the
  // bus transfers and register writes the core must produce, in order.
  task automatic model_run(input logic [1:0] nzv);
    logic [15:0] pc, ir, addr;
    logic [15:0] r [8];
    logic [1:0]  fl;
    bit          take;
    bus_ev_t     b;
    rf_ev_t      w;
    pc = 16'h0000;
    fl = 2'b00;
    for (int i = 0; i < 8; i++) r[i] = 16'h0000;
    r[1] = 16'h0100;
    r[2] = 16'hBEEF;
    bq.delete();
    rq.delete();
    for (int n = 0; n < 32; n++) begin
      ir = mem[pc];
      b = '{addr: pc, we: 1'b0, wdata: 16'h0, fetch: 1'b1};
      bq.push_back(b);
      pc = pc + 16'd1;
      w = '{d: ir[9:7], a: ir[6:4], b: ir[3:1], wsel: 2'b00, fs: 4'h0, val: 16'h0, pc: pc};
      case (ir[15:14])
        2'b00: begin
          w.fs = ir[13:10]; w.val = FU_RESULT;
          fl = (ir[13:10] == FADD) ? nzv : ~nzv;
          r[w.d] = FU_RESULT;
          rq.push_back(w);
        end
        2'b01: begin
          addr = r[ir[6:4]];
          if (!ir[13]) begin
            b = '{addr: addr, we: 1'b0, wdata: 16'h0, fetch: 1'b0};
            bq.push_back(b);
            w.wsel = 2'b01; w.val = mem[addr];
            r[w.d] = w.val;
            rq.push_back(w);
          end else begin
            b = '{addr: addr, we: 1'b1, wdata: r[ir[3:1]], fetch: 1'b0};
            bq.push_back(b);
          end
        end
        2'b10: begin
          case (ir[13:12])
            2'b00:   take = 1'b1;
            2'b01:   take = fl[0];
            2'b10:   take = fl[1];
            default: take = !fl[0];
          endcase
          if (take) pc = pc + {{8{ir[7]}}, ir[7:0]};
        end
        default: begin
          if (ir[13]) return;
          w.wsel = 2'b10; w.val = {9'b0, ir[6:0]};
          r[w.d] = w.val;
          rq.push_back(w);
        end
      endcase
    end
  endtask

  // Compare process: every completed bus transfer and every register
  // write is matched against the model's next expected event.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      if (mem_req_out && mem_ack_in) begin
        if (bq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL bus_extra: got transfer addr %h we %b, expected none", mem_addr_out, mem_we_out);
        end else begin
          be = bq.pop_front();
          chk("bus_addr", mem_addr_out, be.addr);
          chk("bus_we", mem_we_out, be.we);
          if (be.we) chk("bus_wdata", mem_wdata_out, be.wdata);
          if (be.fetch) fetch_cyc.push_back(cyc);
        end
      end
      if (rf_we_out) begin
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rf_extra: got write to r%0d sel %b, expected none", rf_d_addr_out, wb_sel_out);
        end else begin
          re = rq.pop_front();
          chk("rf_d", rf_d_addr_out, re.d);
          chk("rf_a", rf_a_addr_out, re.a);
          chk("rf_b", rf_b_addr_out, re.b);
          chk("wb_sel", wb_sel_out, re.wsel);
          chk("wr_pc", pc_out, re.pc);
          if (re.wsel == 2'b00) chk("alu_fs", fs_out, re.fs);
          if (re.wsel == 2'b10) chk("imm", imm_out, re.val);
          if (re.wsel == 2'b01) chk("ld_in_ack", mem_req_out & mem_ack_in, 1);
          else chk("exec_noreq", mem_req_out, 0);
        end
      end
      if (halted_out) chk("halt_quiet", mem_req_out | rf_we_out, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int wn, input logic [1:0] nzv, input string nm);
    int budget;
    wait_n = wn;
    nz_alu = nzv;
    resp_en = 1'b1;
    fetch_cyc.delete();
    do_reset();
    chk_en = 1'b1;
    budget = 0;
    while (!halted_out && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk({nm, "_halt_reached"}, halted_out, 1);
    repeat (3) @(negedge clk);
    #2;
    chk({nm, "_bus_left"}, bq.size(), 0);
    chk({nm, "_rf_left"}, rq.size(), 0);
  endtask

  task automatic load_prog_a();
    mem[16'h0000] = 16'h0994;   // FADD r3 <- r1, r2
    mem[16'h0001] = 16'h4210;   // LD   r4 <- M[r1]
    mem[16'h0002] = 16'h6014;   // ST   M[r1] <- r2
    mem[16'h0003] = 16'hC2FF;   // LDI  r5 <- 7F
    mem[16'h0004] = 16'hE000;   // HALT
    mem[16'h0100] = 16'h1357;
  endtask

  task automatic pin_prog_a();
    chk("mA_nbus", bq.size(), 7);
    chk("mA_nrf", rq.size(), 3);
    chk("mA_alu_d", rq[0].d, 3);
    chk("mA_alu_fs", rq[0].fs, FADD);
    chk("mA_alu_pc", rq[0].pc, 16'h0001);
    chk("mA_ld_addr", bq[2].addr, 16'h0100);
    chk("mA_ld_d", rq[1].d, 4);
    chk("mA_st_we", bq[4].we, 1);
    chk("mA_st_wdata", bq[4].wdata, 16'hBEEF);
    chk("mA_ldi_val", rq[2].val, 16'h007F);
    chk("mA_ldi_d", rq[2].d, 5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    resp_en = 1'b0;
    wait_n = 0;
    wcnt = 0;
    cyc = 0;
    nz_alu = 2'b01;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hE000;

    // Reset, IDLE outputs, stalled fetch.
    do_reset();
    chk("idle_req", mem_req_out, 0);
    chk("idle_we", mem_we_out, 0);
    chk("idle_addr", mem_addr_out, 0);
    chk("idle_wdata", mem_wdata_out, 0);
    chk("idle_fs", fs_out, FMOVA);
    chk("idle_rfwe", rf_we_out, 0);
    chk("idle_wbsel", wb_sel_out, 0);
    chk("idle_imm", imm_out, 0);
    chk("idle_addrs", {rf_a_addr_out, rf_b_addr_out, rf_d_addr_out}, 0);
    chk("idle_pc", pc_out, 16'h0000);
    chk("idle_halted", halted_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", mem_req_out, 1);
      chk("stall_addr", mem_addr_out, 16'h0000);
      chk("stall_we", mem_we_out, 0);
      chk("stall_pc", pc_out, 16'h0000);
    end
    // Reset in the middle of the unacked fetch.
    rst = 1'b1;
    @(negedge clk);
    chk("abort_req", mem_req_out, 0);

    // ALU, load, store, LDI, HALT with two wait states per access.
    load_prog_a();
    model_run(2'b01);
    pin_prog_a();
    run(2, 2'b01, "progA_w2");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_noreq", mem_req_out, 0);
    end
    chk("halt_held", halted_out, 1);
    chk_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_from_halt_pc", pc_out, 16'h0000);
    chk("rst_from_halt_hlt", halted_out, 0);

    // Same program with zero-wait ack: check minimum latencies.
    model_run(2'b01);
    run(0, 2'b01, "progA_w0");
    chk("lat_n", fetch_cyc.size(), 5);
    if (fetch_cyc.size() == 5) begin
      chk("lat_alu", fetch_cyc[1] - fetch_cyc[0], 3);
      chk("lat_ld", fetch_cyc[2] - fetch_cyc[1], 4);
      chk("lat_st", fetch_cyc[3] - fetch_cyc[2], 4);
      chk("lat_ldi", fetch_cyc[4] - fetch_cyc[3], 3);
    end

    // BZ -2 at 0x0010, preceded by ALU (sets flags) and LDI (must not).
    mem[16'h0000] = 16'h0994;
    mem[16'h0001] = 16'hC2FF;
    mem[16'h0002] = 16'h800D;   // BR always -> 0x0010
    mem[16'h000F] = 16'hE000;
    mem[16'h0010] = 16'h90FE;
    mem[16'h0011] = 16'hE000;
    model_run(2'b01);
    chk("mB_z1_nbus", bq.size(), 5);
    chk("mB_z1_dest", bq[4].addr, 16'h000F);
    run(1, 2'b01, "progB_z1");
    model_run(2'b00);
    chk("mB_z0_dest", bq[4].addr, 16'h0011);
    run(0, 2'b00, "progB_z0");

    // Backward branch to 0xFFFF, PC wrap to 0x0000, then BZ taken.
    mem[16'h0000] = 16'h9005;   // BZ +5 (not taken first pass)
    mem[16'h0001] = 16'h0994;   // FADD, Z=1
    mem[16'h0002] = 16'h80FC;   // BR always -> 0xFFFF
    mem[16'hFFFF] = 16'hC2FF;   // LDI r5
    mem[16'h0006] = 16'hE000;
    model_run(2'b01);
    chk("mC_nbus", bq.size(), 6);
    chk("mC_ffff", bq[3].addr, 16'hFFFF);
    chk("mC_wrap", bq[4].addr, 16'h0000);
    chk("mC_taken", bq[5].addr, 16'h0006);
    chk("mC_ldi_pc", rq[1].pc, 16'h0000);
    run(0, 2'b01, "progC_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cu.md
# cu

Control unit of the MyCPU core: the block that drives the functional unit rather than computing. It fetches 16-bit instructions over a req/ack memory handshake and decodes them into the `fs_t` function select, register-file addresses and write strobes. It also steps the PC and latches the FU's `nz` flags to resolve conditional branches. It sits between instruction/data memory and the datapath (register file + `fu`).

## Interface
- `RESET_PC`, default 16'h0000, PC value loaded on reset.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_rdata_in` in 16: memory read data, valid when `mem_ack_in`=1.
- `mem_ack_in` in 1: memory completes the current request.
- `a_data_in` in 16: register-file read data, port A (load/store address).
- `b_data_in` in 16: register-file read data, port B (store data).
- `nz_in` in 2: FU flags, [1]=N, [0]=Z.
- `mem_req_out` out 1: memory request.
- `mem_we_out` out 1: 1 = write.
- `mem_addr_out` out 16: memory address.
- `mem_wdata_out` out 16: write data.
- `fs_out` out `fs_t` (4): FU function select.
- `rf_a_addr_out`, `rf_b_addr_out`, `rf_d_addr_out` out 3 each: source A, source B, destination.
- `rf_we_out` out 1: register write strobe.
- `wb_sel_out` out 2: write-back source, 00=FU, 01=memory, 10=`imm_out`.
- `imm_out` out 16: zero-extended immediate.
- `pc_out` out 16: current PC.
- `halted_out` out 1: core halted.

## Operation
- Instruction bits:
  - [15:14] is the class.
  - ALU fields: fs=[13:10], d=[9:7], a=[6:4], b=[3:1].
  - Register address outputs come from the instruction register (IR) fields in every state.
- Classes:
  - **00 ALU**: `fs_out`=IR[13:10]; writes R[d] from the FU; flags<=`nz_in`.
  - **01 MEM**:
    - IR[13]=0 (load): R[d]<=M[`a_data_in`].
    - IR[13]=1 (store): M[`a_data_in`]<=`b_data_in`.
  - **10 BR**:
    - Condition IR[13:12]: 00 always, 01 Z, 10 N, 11 !Z.
    - If taken, PC<=PC+sext(IR[7:0]). PC is already incremented at this point.
  - **11**:
    - IR[13]=0 (LDI): R[d]<={9'b0,IR[6:0]}.
    - IR[13]=1 (HALT).
- Only ALU instructions update the flags. Branches use the flags register, not `nz_in`.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
  - IDLE → FETCH.
  - FETCH → DECODE on ack.
  - DECODE → EXEC.
  - EXEC → FETCH (ALU/BR/LDI), MEM (class 01) or HALT.
  - MEM → FETCH on ack.
  - HALT is left only by `rst`.
- Default outputs: `fs_out`=FMOVA, `rf_we_out`=0, `mem_req_out`=0, `wb_sel_out`=00.

## Timing
- Reset values: state=IDLE, PC=`RESET_PC`, IR=0, flags=00.
- Outputs in IDLE: all zero, `fs_out`=FMOVA, `pc_out`=`RESET_PC`, `halted_out`=0.
- `rst` has priority in every state. A request aborted mid-handshake drops `mem_req_out` in the cycle after `rst` is sampled.
- FETCH:
  - `mem_req_out`=1, `mem_we_out`=0, `mem_addr_out`=PC, held until `mem_ack_in`=1.
  - In the ack cycle, IR<=`mem_rdata_in` and PC<=PC+1.
  - PC wraps FFFF→0000.
- `mem_ack_in` is ignored when `mem_req_out`=0.
- DECODE: exactly 1 cycle, no strobes.
- EXEC, 1 cycle:
  - ALU: `fs_out`=IR fs, `rf_we_out`=1, `wb_sel_out`=00; flags captured at the clock edge ending EXEC.
  - LDI: `rf_we_out`=1, `wb_sel_out`=10.
  - BR: PC updated at the end of EXEC.
- MEM:
  - Drives `mem_req_out`=1, `mem_addr_out`=`a_data_in`, `mem_we_out`=IR[13], `mem_wdata_out`=`b_data_in`.
  - Load: in the ack cycle, `rf_we_out`=1 and `wb_sel_out`=01; read data is consumed combinationally.
- `rf_we_out` is exactly one cycle per ALU, LDI or load instruction.
- Minimum latency with zero-wait ack: ALU/BR/LDI 3 cycles; load/store 4 cycles.
- HALT: `halted_out`=1; no requests or strobes.
- Branch offset arithmetic is 16-bit modulo.

## Test plan
1. **Reset and fetch stall**
   - Stimulus: `rst` 2 cycles, release; hold `mem_ack_in`=0 for 3 cycles.
   - Response: one IDLE cycle with all outputs 0; then `mem_req_out`=1 with `mem_addr_out`=0000 held all 3 cycles; `pc_out` stays 0000.
2. **ALU**
   - Stimulus: fetch 0x0994 (FADD d=3 a=1 b=2), `nz_in`=01.
   - Response: in EXEC, `fs_out`=FADD, `rf_a_addr_out`=1, `rf_b_addr_out`=2, `rf_d_addr_out`=3, `rf_we_out`=1 for one cycle; flags=01 afterwards; `pc_out`=0001.
3. **Load and store with wait states**
   - Load: 0x4210 with `a_data_in`=0x0100 and ack after 2 wait cycles → `mem_addr_out`=0x0100, `mem_we_out`=0; `rf_we_out`=1 and `wb_sel_out`=01 only in the ack cycle; `rf_d_addr_out`=4.
   - Store: 0x6014 with `b_data_in`=0xBEEF → `mem_we_out`=1, `mem_wdata_out`=0xBEEF; no `rf_we_out`.
4. **Branch**
   - Stimulus: 0x90FE (BZ −2) at 0x0010.
   - Response: Z=1 → next fetch address 0x000F; Z=0 → 0x0011. A preceding non-ALU instruction leaves the flags unchanged.
5. **LDI and HALT**
   - Stimulus: 0xC2FF, then 0xE000.
   - Response: `imm_out`=0x007F, `wb_sel_out`=10, `rf_d_addr_out`=5; then `halted_out`=1 with no further `mem_req_out` for 20 cycles. `rst` returns to IDLE with `pc_out`=`RESET_PC`.
6. **Reset mid-fetch and PC wrap**
   - Mid-fetch: assert `rst` during an unacked FETCH → `mem_req_out`=0 the next cycle.
   - Wrap: fetch at PC=FFFF → `pc_out`=0000.
